atm_controller: RTL and testbench

- Single-account ATM session controller FSM.
- Takes a card-insert event, a language select and a 4-bit PIN, then serves balance, deposit and withdraw requests against an internal balance register.
- Emits one-cycle completion pulses per operation and a session-finished pulse.
- Sits between the front-panel input decoder and the display/dispense logic.

---
 rtl/atm_controller_if.sv | 36 +++
 rtl/atm_controller.sv | 181 ++++++++++++++++++
 tb/tb_atm_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_controller_if.sv
// Front-panel request / display-status bundle between the ATM session controller
// and its neighbours; the controller is the slave side.
interface atm_controller_if #(
  parameter int AMOUNT_W = 32
);
  logic                cardIn;
  logic                Language;
  logic [3:0]          password;
  logic [1:0]          opCode;
  logic [AMOUNT_W-1:0] inputAmount;
  logic                moneyDeposited;
  logic                Another_Operation;
  logic                ejectCard;

  logic                correctPassword;
  logic                Balance_Shown;
  logic                Deposited_Successfully;
  logic                Withdrawed_Successfully;
  logic                ATM_Usage_Finished;
  logic [AMOUNT_W-1:0] balance;
  logic                lang;

  modport master (
    output cardIn, Language, password, opCode, inputAmount,
           moneyDeposited, Another_Operation, ejectCard,
    input  correctPassword, Balance_Shown, Deposited_Successfully,
           Withdrawed_Successfully, ATM_Usage_Finished, balance, lang
  );

  modport slave (
    input  cardIn, Language, password, opCode, inputAmount,
           moneyDeposited, Another_Operation, ejectCard,
    output correctPassword, Balance_Shown, Deposited_Successfully,
           Withdrawed_Successfully, ATM_Usage_Finished, balance, lang
  );
endinterface

// File: rtl/atm_controller.sv
// Single-account ATM session FSM with a persistent balance register.
// Optional macro ATM_PIN_LOCKOUT_EN: eject after MAX_TRIES consecutive wrong PINs.
module atm_controller #(
  parameter int          AMOUNT_W     = 32,
  parameter logic [3:0]  PIN          = 4'b1010,
  parameter int unsigned INIT_BALANCE = 32'd1000
`ifdef ATM_PIN_LOCKOUT_EN
  ,
  parameter int          MAX_TRIES    = 3
`endif
) (
  input  logic             clk,
  input  logic             reset,
  atm_controller_if.slave  atm
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LANG     = 4'd1,
    S_PASS     = 4'd2,
    S_MENU     = 4'd3,
    S_BALANCE  = 4'd4,
    S_DEPOSIT  = 4'd5,
    S_WITHDRAW = 4'd6,
    S_ANOTHER  = 4'd7,
    S_EJECT    = 4'd8
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [AMOUNT_W-1:0] r_balance, w_balance_nxt;
  logic                r_lang, w_lang_nxt;
  logic                r_auth, w_auth_nxt;
  logic                r_bal_shown, w_bal_shown_nxt;
  logic                r_dep_ok, w_dep_ok_nxt;
  logic                r_wd_ok, w_wd_ok_nxt;
  logic                r_fin, w_fin_nxt;
  logic [AMOUNT_W:0]   w_dep_sum;
`ifdef ATM_PIN_LOCKOUT_EN
  logic [1:0]          r_tries, w_tries_nxt;
`endif

  // Extra carry bit exposes deposit overflow.
  assign w_dep_sum = {1'b0, r_balance} + {1'b0, atm.inputAmount};

  // Next-state and next-output logic; abort outranks every normal transition.
  always_comb begin
    w_state_nxt     = r_state;
    w_balance_nxt   = r_balance;
    w_lang_nxt      = r_lang;
    w_auth_nxt      = r_auth;
    w_bal_shown_nxt = 1'b0;
    w_dep_ok_nxt    = 1'b0;
    w_wd_ok_nxt     = 1'b0;
    w_fin_nxt       = 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
    w_tries_nxt     = r_tries;
`endif
    if (atm.ejectCard && (r_state != S_IDLE) && (r_state != S_EJECT)) begin
      w_state_nxt = S_EJECT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (atm.cardIn) w_state_nxt = S_LANG;
          else            w_state_nxt = S_IDLE;
        end
        S_LANG: begin
          w_lang_nxt  = atm.Language;
          w_state_nxt = S_PASS;
        end
        S_PASS: begin
          if (atm.password == PIN) begin
            w_state_nxt = S_MENU;
            w_auth_nxt  = 1'b1;
`ifdef ATM_PIN_LOCKOUT_EN
            w_tries_nxt = 2'd0;
`endif
          end else begin
`ifdef ATM_PIN_LOCKOUT_EN
            if (r_tries == 2'(MAX_TRIES - 1)) begin
              w_state_nxt = S_EJECT;
            end else begin
              w_tries_nxt = r_tries + 2'd1;
            end
`else
            w_state_nxt = S_PASS;
`endif
          end
        end
        S_MENU: begin
          case (atm.opCode)
            2'b01:   w_state_nxt = S_BALANCE;
            2'b10:   w_state_nxt = S_DEPOSIT;
            2'b11:   w_state_nxt = S_WITHDRAW;
            default: w_state_nxt = S_MENU;
          endcase
        end
        S_BALANCE: begin
          w_bal_shown_nxt = 1'b1;
          w_state_nxt     = S_ANOTHER;
        end
        S_DEPOSIT: begin
          if (atm.moneyDeposited) begin
            if (!w_dep_sum[AMOUNT_W]) begin
              w_balance_nxt = w_dep_sum[AMOUNT_W-1:0];
              w_dep_ok_nxt  = 1'b1;
            end else begin
              w_balance_nxt = r_balance;
            end
            w_state_nxt = S_ANOTHER;
          end else begin
            w_state_nxt = S_DEPOSIT;
          end
        end
        S_WITHDRAW: begin
          if ((atm.inputAmount != {AMOUNT_W{1'b0}}) && (atm.inputAmount <= r_balance)) begin
            w_balance_nxt = r_balance - atm.inputAmount;
            w_wd_ok_nxt   = 1'b1;
          end else begin
            w_balance_nxt = r_balance;
          end
          w_state_nxt = S_ANOTHER;
        end
        S_ANOTHER: begin
          if (atm.Another_Operation) w_state_nxt = S_MENU;
          else                       w_state_nxt = S_EJECT;
        end
        S_EJECT: begin
          w_fin_nxt   = 1'b1;
          w_auth_nxt  = 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
          w_tries_nxt = 2'd0;
`endif
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered datapath and output pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_balance   <= AMOUNT_W'(INIT_BALANCE);
      r_lang      <= 1'b0;
      r_auth      <= 1'b0;
      r_bal_shown <= 1'b0;
      r_dep_ok    <= 1'b0;
      r_wd_ok     <= 1'b0;
      r_fin       <= 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
      r_tries     <= 2'd0;
`endif
    end else begin
      r_balance   <= w_balance_nxt;
      r_lang      <= w_lang_nxt;
      r_auth      <= w_auth_nxt;
      r_bal_shown <= w_bal_shown_nxt;
      r_dep_ok    <= w_dep_ok_nxt;
      r_wd_ok     <= w_wd_ok_nxt;
      r_fin       <= w_fin_nxt;
`ifdef ATM_PIN_LOCKOUT_EN
      r_tries     <= w_tries_nxt;
`endif
    end
  end

  assign atm.correctPassword         = r_auth;
  assign atm.Balance_Shown           = r_bal_shown;
  assign atm.Deposited_Successfully  = r_dep_ok;
  assign atm.Withdrawed_Successfully = r_wd_ok;
  assign atm.ATM_Usage_Finished      = r_fin;
  assign atm.balance                 = r_balance;
  assign atm.lang                    = r_lang;

endmodule

// File: tb/tb_atm_controller.sv
// Directed + randomized bench for atm_controller with a pulse scoreboard.
module tb_atm_controller;
  localparam int AW = 32;
  localparam logic [3:0] P_BAL = 4'b1000;
  localparam logic [3:0] P_DEP = 4'b0100;
  localparam logic [3:0] P_WD  = 4'b0010;
  localparam logic [3:0] P_FIN = 4'b0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atm_controller_if #(.AMOUNT_W(AW)) atm ();
  atm_controller #(.AMOUNT_W(AW)) dut (.clk(clk), .reset(reset), .atm(atm));

  typedef struct packed {
    logic [3:0]    pulses;
    logic [AW-1:0] bal;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            sb_en = 1'b0;
  bit            rnd_en = 1'b0;
  logic [AW-1:0] exp_bal;
  logic [3:0]    w_pulses;

  assign w_pulses = {atm.Balance_Shown, atm.Deposited_Successfully,
                     atm.Withdrawed_Successfully, atm.ATM_Usage_Finished};

  // Pulse monitor: scoreboard pop in directed phase, exclusivity check in random phase.
  always @(negedge clk) begin
    if (sb_en && (w_pulses != 4'b0000)) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed pulses=%b expected none", w_pulses);
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        n_cmp++;
        assert ({w_pulses, atm.balance} === {mon_e.pulses, mon_e.bal}) else begin
          n_err++;
          $error("FAIL sb_pulse: observed pulses=%b bal=%0d expected pulses=%b bal=%0d",
                 w_pulses, atm.balance, mon_e.pulses, mon_e.bal);
        end
      end
    end
    if (rnd_en) begin
      n_cmp++;
      assert (($countones(w_pulses[3:1]) <= 1) && !(w_pulses[0] && (w_pulses[3:1] != 3'b000))) else begin
        n_err++;
        $error("FAIL rnd_exclusive: observed pulses=%b expected at most one, none with finish", w_pulses);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] p, input logic [AW-1:0] b);
    sb_q.push_back('{pulses: p, bal: b});
  endtask

  task automatic idle_inputs();
    atm.cardIn = 1'b0; atm.Language = 1'b0; atm.password = 4'b0000;
    atm.opCode = 2'b00; atm.inputAmount = '0; atm.moneyDeposited = 1'b0;
    atm.Another_Operation = 1'b0; atm.ejectCard = 1'b0;
  endtask

  // IDLE -> LANG -> PASS -> (MENU if pin is right); Language flipped after latch.
  task automatic start_session(input logic l, input logic [3:0] pin);
    atm.cardIn = 1'b1; atm.Language = l; atm.password = pin;
    tick();
    atm.cardIn = 1'b0;
    tick();
    atm.Language = ~l;
    tick();
  endtask

  task automatic do_op(input logic [1:0] op, input logic [AW-1:0] amt, input int wait_n, input logic another);
    logic [AW:0] sum;
    atm.opCode = op; atm.inputAmount = amt;
    tick();
    atm.opCode = 2'b00;
    case (op)
      2'b01: push(P_BAL, exp_bal);
      2'b10: begin
        sum = {1'b0, exp_bal} + {1'b0, amt};
        if (!sum[AW]) begin
          exp_bal = sum[AW-1:0];
          push(P_DEP, exp_bal);
        end
      end
      2'b11: begin
        if ((amt != '0) && (amt <= exp_bal)) begin
          exp_bal = exp_bal - amt;
          push(P_WD, exp_bal);
        end
      end
      default: ;
    endcase
    if (op == 2'b10) begin
      atm.moneyDeposited = 1'b0;
      for (int i = 0; i < wait_n; i++) begin
        tick();
        chk("deposit_wait", 64'(atm.Deposited_Successfully), 64'd0);
      end
      atm.moneyDeposited = 1'b1;
    end
    tick();
    atm.moneyDeposited = 1'b0;
    chk("op_balance", 64'(atm.balance), 64'(exp_bal));
    atm.Another_Operation = another;
    tick();
    if (!another) begin
      push(P_FIN, exp_bal);
      tick();
      chk("session_end_auth", 64'(atm.correctPassword), 64'd0);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("reset_auth", 64'(atm.correctPassword), 64'd0);
    chk("reset_pulses", 64'(w_pulses), 64'd0);
    chk("reset_balance", 64'(atm.balance), 64'd1000);
    chk("reset_lang", 64'(atm.lang), 64'd0);
    reset = 1'b1;
    exp_bal = 32'd1000;
    sb_en = 1'b1;

    start_session(1'b1, 4'b1010);
    chk("auth_ok", 64'(atm.correctPassword), 64'd1);
    chk("lang_latched", 64'(atm.lang), 64'd1);
    do_op(2'b01, 32'd0, 0, 1'b1);
    do_op(2'b11, 32'd1001, 0, 1'b1);
    do_op(2'b11, 32'd0, 0, 1'b1);
    do_op(2'b11, 32'h40, 0, 1'b0);
    chk("withdraw_balance", 64'(atm.balance), 64'd936);
    chk("lang_kept", 64'(atm.lang), 64'd1);

    start_session(1'b0, 4'b1010);
    chk("lang_second", 64'(atm.lang), 64'd0);
    do_op(2'b10, 32'd128, 3, 1'b0);
    chk("deposit_balance", 64'(atm.balance), 64'd1064);

    start_session(1'b0, 4'b1010);
    do_op(2'b10, 32'hFFFF_FFFF, 0, 1'b1);
    do_op(2'b11, 32'h40, 0, 1'b0);
    chk("overflow_then_wd", 64'(atm.balance), 64'd1000);

    atm.cardIn = 1'b1; atm.password = 4'b0000;
    tick();
    atm.cardIn = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrong_pin_auth", 64'(atm.correctPassword), 64'd0);
    end
`ifdef ATM_PIN_LOCKOUT_EN
    push(P_FIN, exp_bal);
    tick();
    chk("lockout_auth", 64'(atm.correctPassword), 64'd0);
`else
    atm.password = 4'b1010;
    tick();
    chk("late_pin_auth", 64'(atm.correctPassword), 64'd1);
    atm.ejectCard = 1'b1;
    tick();
    atm.ejectCard = 1'b0;
    push(P_FIN, exp_bal);
    tick();
    chk("eject_auth", 64'(atm.correctPassword), 64'd0);
`endif

    start_session(1'b0, 4'b1010);
    atm.opCode = 2'b10; atm.inputAmount = 32'd500;
    tick();
    atm.opCode = 2'b00; atm.moneyDeposited = 1'b0;
    tick();
    atm.ejectCard = 1'b1; atm.moneyDeposited = 1'b1;
    tick();
    atm.ejectCard = 1'b0; atm.moneyDeposited = 1'b0;
    chk("abort_balance", 64'(atm.balance), 64'd1000);
    push(P_FIN, exp_bal);
    tick();
    chk("abort_auth", 64'(atm.correctPassword), 64'd0);

    start_session(1'b1, 4'b1010);
    atm.opCode = 2'b11; atm.inputAmount = 32'd100;
    tick();
    atm.opCode = 2'b00;
    reset = 1'b0;
    tick();
    chk("midreset_auth", 64'(atm.correctPassword), 64'd0);
    chk("midreset_pulses", 64'(w_pulses), 64'd0);
    chk("midreset_balance", 64'(atm.balance), 64'd1000);
    chk("midreset_lang", 64'(atm.lang), 64'd0);
    reset = 1'b1;
    exp_bal = 32'd1000;
    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    sb_en = 1'b0;
    rnd_en = 1'b1;
    for (int i = 0; i < 7000; i++) begin
      atm.cardIn = 1'($urandom_range(0, 1));
      atm.Language = 1'($urandom_range(0, 1));
      atm.password = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1010;
      atm.opCode = 2'($urandom);
      atm.inputAmount = 32'($urandom_range(0, 2000));
      atm.moneyDeposited = 1'($urandom_range(0, 1));
      atm.Another_Operation = 1'($urandom_range(0, 1));
      atm.ejectCard = ($urandom_range(0, 15) == 0);
      tick();
    end
    rnd_en = 1'b0;
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
